// File: rtl/rrp_mult_arb_if.sv
// Requester, multiplier and result signals of the two-port multiplier arbiter.
// master = requesters plus multiplier side, slave = the arbiter.
interface rrp_mult_arb_if #(
  parameter int N = 12,
  parameter int P = 27
);
  logic         req0_valid, req1_valid;
  logic         req0_ready, req1_ready;
  logic [N-1:0] req0_x, req0_y, req1_x, req1_y;
  logic [N-1:0] mul_x, mul_y;
  logic [P-1:0] mul_p;
  logic         res0_valid, res1_valid;
  logic [P-1:0] res_p;
  logic         busy;

  modport master (
    output req0_valid, req1_valid, req0_x, req0_y, req1_x, req1_y, mul_p,
    input  req0_ready, req1_ready, mul_x, mul_y, res0_valid, res1_valid, res_p, busy
  );

  modport slave (
    input  req0_valid, req1_valid, req0_x, req0_y, req1_x, req1_y, mul_p,
    output req0_ready, req1_ready, mul_x, mul_y, res0_valid, res1_valid, res_p, busy
  );
endinterface

// File: rtl/rrp_mult_arb.sv
// Round-robin share of one pipelined signed-digit multiplier between two requesters;
// a requester tag travels beside each operand pair and steers the result strobe.
module rrp_mult_arb #(
  parameter int RADIX   = 4,
  parameter int WIDTH   = 4,
  parameter int LATENCY = WIDTH + 3
) (
  input  logic          clock,
  input  logic          reset,
  rrp_mult_arb_if.slave bus
);
  localparam int D = $clog2(RADIX) + 1;
  localparam int N = D * WIDTH;

  typedef struct packed {
    logic vld;
    logic id;
  } tag_t;

  logic              r_ptr;
  logic [N-1:0]      r_mul_x, r_mul_y;
  // Stage 0 rides with mul_x/mul_y; stage LATENCY lines up with the product on mul_p.
  tag_t [LATENCY:0]  r_tag;

  logic [1:0]        w_req_vld;
  logic [1:0][N-1:0] w_req_x, w_req_y;
  logic              w_grant, w_gid, w_busy;

  assign w_req_vld = {bus.req1_valid, bus.req0_valid};
  assign w_req_x   = {bus.req1_x, bus.req0_x};
  assign w_req_y   = {bus.req1_y, bus.req0_y};

  always_comb begin
    w_grant = 1'b0;
    w_gid   = 1'b0;
    if (!reset && |w_req_vld) begin
      w_grant = 1'b1;
      w_gid   = (&w_req_vld) ? r_ptr : w_req_vld[1];
    end
  end

  always_comb begin
    w_busy = 1'b0;
    for (int i = 0; i <= LATENCY; i++) w_busy = w_busy | r_tag[i].vld;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_ptr   <= 1'b0;
      r_mul_x <= '0;
      r_mul_y <= '0;
      r_tag   <= '0;
    end else begin
      // Idle edges feed 0*0 so the multiplier never sees stale operands.
      r_mul_x <= w_grant ? w_req_x[w_gid] : '0;
      r_mul_y <= w_grant ? w_req_y[w_gid] : '0;
      if (w_grant) r_ptr <= ~w_gid;
      r_tag   <= {r_tag[LATENCY-1:0], w_grant, w_gid};
    end
  end

  assign bus.req0_ready = w_grant && !w_gid;
  assign bus.req1_ready = w_grant &&  w_gid;
  assign bus.mul_x      = r_mul_x;
  assign bus.mul_y      = r_mul_y;
  assign bus.res0_valid = !reset && r_tag[LATENCY].vld && !r_tag[LATENCY].id;
  assign bus.res1_valid = !reset && r_tag[LATENCY].vld &&  r_tag[LATENCY].id;
  assign bus.res_p      = bus.mul_p;
  assign bus.busy       = !reset && w_busy;
endmodule
